// File: rtl/rca_seq_ctrl_pkg.sv
// ============================================================================
// Module      : rca_seq_pkg
// Description : Shared state encoding and source-select constants for the
//               IO-register / RCA sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rca_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4,
        CLEAR = 3'd5
    } state_t;

    localparam logic SRC_EXT = 1'b0;
    localparam logic SRC_SUM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rca_seq_ctrl_iter_down_cnt.sv
// ============================================================================
// Module      : iter_down_cnt
// Description : Loadable down-counter for the add-pass count, with zero/one
//               flags. Load takes priority over decrement.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_down_cnt #(
    parameter int ITER_W = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [ITER_W-1:0] d_i,
    output logic              is_zero_o,
    output logic              is_one_o
);

    logic [ITER_W-1:0] cnt_q;
    logic [ITER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = d_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero_o = (cnt_q == '0);
    assign is_one_o  = (cnt_q == {{(ITER_W-1){1'b0}}, 1'b1});

endmodule

`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
// ============================================================================
// Module      : rca_seq_ctrl
// Description : Load / N x add-writeback / store sequencer driving the IO
//               register strobes and input-source mux of the RCA datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int ITER_W = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [ITER_W-1:0] iters,
    input  logic              abort,
    input  logic              c_out,
    output logic              reg_clr,
    output logic              reg_ld,
    output logic              reg_st,
    output logic              src_sel,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    state_t state_q;
    state_t state_d;
    logic   ovf_q;
    logic   ovf_d;
    logic   cnt_load;
    logic   cnt_en;
    logic   cnt_is_zero;
    logic   cnt_is_one;

    assign cnt_load = (state_q == IDLE) && start;
    assign cnt_en   = (state_q == ADD);

    iter_down_cnt #(
        .ITER_W (ITER_W)
    ) u_iter_cnt (
        .clk       (clk),
        .clr_n     (clr_n),
        .load_i    (cnt_load),
        .en_i      (cnt_en),
        .d_i       (iters),
        .is_zero_o (cnt_is_zero),
        .is_one_o  (cnt_is_one)
    );

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = CLEAR;
                end else if (cnt_is_zero) begin
                    state_d = STORE;
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                ovf_d = ovf_q | c_out;
                if (abort) begin
                    state_d = CLEAR;
                end else if (cnt_is_one) begin
                    state_d = STORE;
                end
            end
            STORE:   state_d = abort ? CLEAR : DONE;
            DONE:    state_d = abort ? CLEAR : IDLE;
            CLEAR: begin
                state_d = IDLE;
                ovf_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    // Pure state decode keeps the strobes glitch-free of input paths.
    always_comb begin
        reg_clr = 1'b0;
        reg_ld  = 1'b0;
        reg_st  = 1'b0;
        src_sel = SRC_EXT;
        done    = 1'b0;
        case (state_q)
            LOAD:  reg_ld = 1'b1;
            ADD: begin
                reg_ld  = 1'b1;
                src_sel = SRC_SUM;
            end
            STORE: reg_st  = 1'b1;
            DONE:  done    = 1'b1;
            CLEAR: reg_clr = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
// ============================================================================
// Module      : tb_rca_seq_ctrl
// Description : Self-checking bench for rca_seq_ctrl against a cycle-index
//               model of the load/add/store/done timeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rca_seq_ctrl;

    localparam int ITER_W = 4;

    logic              clk;
    logic              clr_n;
    logic              start;
    logic [ITER_W-1:0] iters;
    logic              abort;
    logic              c_out;
    logic              reg_clr;
    logic              reg_ld;
    logic              reg_st;
    logic              src_sel;
    logic              busy;
    logic              done;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    rca_seq_ctrl #(
        .ITER_W (ITER_W)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (start),
        .iters   (iters),
        .abort   (abort),
        .c_out   (c_out),
        .reg_clr (reg_clr),
        .reg_ld  (reg_ld),
        .reg_st  (reg_st),
        .src_sel (src_sel),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes must be one-hot-or-zero at every instant, including async reset.
    always @(reg_clr or reg_ld or reg_st) begin
        #0;
        if (!$onehot0({reg_clr, reg_ld, reg_st})) begin
            errors++;
            $display("FAIL onehot_any_time: strobes clr/ld/st=%b%b%b", reg_clr, reg_ld, reg_st);
        end
    end

    // Expected {reg_clr, reg_ld, reg_st, src_sel, busy, done, ovf} in cycle k
    // after a start accepted with count n; ab = cycle in which abort is high (0 = never);
    // cm bit j = c_out level during cycle j.
    function automatic logic [6:0] model(int n, int ab, logic [31:0] cm, int k);
        int  ph;
        logic o;
        if (ab > 0 && k == ab + 1)      ph = 5;
        else if (ab > 0 && k > ab + 1)  ph = 0;
        else if (k == 1)                ph = 1;
        else if (k >= 2 && k <= n + 1)  ph = 2;
        else if (k == n + 2)            ph = 3;
        else if (k == n + 3)            ph = 4;
        else                            ph = 0;
        o = 1'b0;
        for (int j = 2; j <= n + 1; j++) begin
            if (j < k && (ab == 0 || j < ab) && cm[j]) o = 1'b1;
        end
        if (ab > 0 && k > ab + 1) o = 1'b0;
        return {ph == 5, (ph == 1 || ph == 2), ph == 3, ph == 2, ph != 0, ph == 4, o};
    endfunction

    // Starts one sequence and compares every cycle up to and including the first idle cycle.
    task automatic run_sequence(input string name, input int n, input int ab, input logic [31:0] cm_in);
        logic [31:0] cm;
        logic [6:0]  exp, got;
        int          last;
        cm   = cm_in;
        if (ab > 0) cm[ab] = 1'b0;
        last = (ab > 0) ? ab + 2 : n + 4;
        start = 1'b1;
        iters = ITER_W'(n);
        abort = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= last; k++) begin
            exp = model(n, ab, cm, k);
            got = {reg_clr, reg_ld, reg_st, src_sel, busy, done, ovf};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s n=%0d cycle %0d: got clr,ld,st,sel,busy,done,ovf=%b expected %b",
                         name, n, k, got, exp);
            end
            checks++;
            if (!$onehot0({reg_clr, reg_ld, reg_st})) begin
                errors++;
                $display("FAIL %s onehot cycle %0d: got %b%b%b expected at most one set",
                         name, k, reg_clr, reg_ld, reg_st);
            end
            c_out = cm[k];
            abort = (k == ab);
            iters = ITER_W'($urandom);
            start = (k < last) ? 1'($urandom) : 1'b0;
            if (k < last) begin
                @(posedge clk); #1;
            end
        end
        abort = 1'b0;
        c_out = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        start = 1'b0; iters = '0; abort = 1'b0; c_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({reg_clr, reg_ld, reg_st, src_sel, busy, done, ovf} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {reg_clr, reg_ld, reg_st, src_sel, busy, done, ovf});
        end
        clr_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy got %b expected 0", busy);
        end
        run_sequence("n3_basic", 3, 0, 32'h0);
    endtask

    task automatic test_zero_iters();
        run_sequence("zero_iters", 0, 0, 32'hFFFF_FFFF);
    endtask

    task automatic test_overflow();
        run_sequence("overflow", 2, 0, 32'h0000_0008);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky_idle: got %b expected 1", ovf);
        end
        run_sequence("ovf_cleared_on_start", 1, 0, 32'h0);
    endtask

    task automatic test_abort();
        run_sequence("abort_add", 5, 3, 32'h0);
        run_sequence("abort_load", 4, 1, 32'hFFFF_FFFF);
        run_sequence("abort_store", 2, 4, 32'hFFFF_FFFF);
        run_sequence("abort_done", 1, 4, 32'h0);
    endtask

    task automatic test_max_iters();
        run_sequence("max_iters", (1 << ITER_W) - 1, 0, 32'h0001_0000);
    endtask

    task automatic test_held_start();
        logic [6:0] exp, got;
        start = 1'b1; iters = 4'd4; abort = 1'b0; c_out = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            exp = model(4, 0, 32'h0, k);
            got = {reg_clr, reg_ld, reg_st, src_sel, busy, done, ovf};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL held_start cycle %0d: got %b expected %b", k, got, exp);
            end
            iters = ITER_W'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        if ({reg_ld, src_sel, busy} !== 3'b101) begin
            errors++;
            $display("FAIL held_start_restart: ld,sel,busy got %b expected 101", {reg_ld, src_sel, busy});
        end
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (reg_clr !== 1'b1) begin
            errors++;
            $display("FAIL held_start_cleanup: reg_clr got %b expected 1", reg_clr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        start = 1'b1; iters = 4'd6; abort = 1'b0; c_out = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({reg_ld, src_sel} !== 2'b11) begin
            errors++;
            $display("FAIL async_pre_add: ld,sel got %b expected 11", {reg_ld, src_sel});
        end
        #2 clr_n = 1'b0;
        #1;
        checks++;
        if ({reg_clr, reg_ld, reg_st, src_sel, busy, done, ovf} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b expected 0000000",
                     {reg_clr, reg_ld, reg_st, src_sel, busy, done, ovf});
        end
        @(posedge clk); #1;
        c_out = 1'b0;
        clr_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || reg_clr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_no_clear: busy,clr got %b%b expected 00", busy, reg_clr);
        end
        run_sequence("after_async_reset", 2, 0, 32'h0);
    endtask

    task automatic test_random();
        int n, ab;
        for (int t = 0; t < 25; t++) begin
            n  = $urandom_range((1 << ITER_W) - 1, 0);
            ab = ($urandom_range(2, 0) == 0) ? $urandom_range(n + 3, 1) : 0;
            run_sequence("random", n, ab, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_zero_iters();
        test_overflow();
        test_abort();
        test_max_iters();
        test_held_start();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
